// File: rtl/data_mem_responder.sv
// data_mem_responder: pipelined 16-bit data memory with a fixed read latency.
// Stores commit at the accepting edge. Loads read the array at the accepting edge and
// travel through a LATENCY-deep shift pipeline. The last stage of that pipeline drives
// data_out, resp_addr and data_valid.
module data_mem_responder #(
    parameter int unsigned ADDR_W  = 15,
    parameter int unsigned LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic [15:0] resp_addr,
    output logic        busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [15:0]       mem [DEPTH];
    logic [ADDR_W-1:0] word_idx;
    logic              load_acc;
    logic              store_acc;

    // Pipeline stage i holds a load accepted i edges ago; stage LATENCY-1 is the output.
    logic [LATENCY-1:0] vld_q;
    logic [15:0]        dat_q [LATENCY];
    logic [15:0]        adr_q [LATENCY];

    // Values presented to each stage on the next edge.
    logic [LATENCY-1:0] vld_in;
    logic [15:0]        dat_in_s [LATENCY];
    logic [15:0]        adr_in_s [LATENCY];

    assign word_idx  = addr[ADDR_W:1];
    assign load_acc  = enable & ~wr;
    assign store_acc = enable & wr;

    // Store port: array contents survive reset.
    always_ff @(posedge clk) begin
        if (store_acc) begin
            mem[word_idx] <= data_in;
        end
    end

    // Stage inputs: stage 0 takes the array read, later stages take their predecessor.
    always_comb begin
        vld_in      = '0;
        vld_in[0]   = load_acc;
        dat_in_s[0] = mem[word_idx];
        adr_in_s[0] = {addr[15:1], 1'b0};
        for (int i = 1; i < int'(LATENCY); i++) begin
            vld_in[i]   = vld_q[i-1];
            dat_in_s[i] = dat_q[i-1];
            adr_in_s[i] = adr_q[i-1];
        end
    end

    // Pipeline registers. Data only moves with a valid load, so the output stage holds its
    // last returned value between responses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
            for (int i = 0; i < int'(LATENCY); i++) begin
                dat_q[i] <= '0;
                adr_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_in;
            for (int i = 0; i < int'(LATENCY); i++) begin
                if (vld_in[i]) begin
                    dat_q[i] <= dat_in_s[i];
                    adr_q[i] <= adr_in_s[i];
                end
            end
        end
    end

    // Busy: a load is being accepted or is still in a stage short of the output.
    always_comb begin
        busy = load_acc;
        for (int i = 0; i < int'(LATENCY) - 1; i++) begin
            busy = busy | vld_q[i];
        end
        busy = busy & rst;
    end

    assign data_out   = dat_q[LATENCY-1];
    assign resp_addr  = adr_q[LATENCY-1];
    assign data_valid = vld_q[LATENCY-1];

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder. It runs three instances on shared stimulus:
//   0: ADDR_W=15, LATENCY=4
//   1: ADDR_W=4,  LATENCY=4 (aliasing)
//   2: ADDR_W=15, LATENCY=1
// A time-slot scoreboard predicts when each response must appear.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;

    logic [15:0] dout  [3];
    logic        dv    [3];
    logic [15:0] raddr [3];
    logic        bsy   [3];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_W(15), .LATENCY(4)) u_dut0 (
        .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr), .data_in(data_in),
        .data_out(dout[0]), .data_valid(dv[0]), .resp_addr(raddr[0]), .busy(bsy[0])
    );
    data_mem_responder #(.ADDR_W(4), .LATENCY(4)) u_dut1 (
        .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr), .data_in(data_in),
        .data_out(dout[1]), .data_valid(dv[1]), .resp_addr(raddr[1]), .busy(bsy[1])
    );
    data_mem_responder #(.ADDR_W(15), .LATENCY(1)) u_dut2 (
        .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr), .data_in(data_in),
        .data_out(dout[2]), .data_valid(dv[2]), .resp_addr(raddr[2]), .busy(bsy[2])
    );

    function automatic int lat_of(input int d);
        return (d == 2) ? 1 : 4;
    endfunction

    function automatic int aw_of(input int d);
        return (d == 1) ? 4 : 15;
    endfunction

    // Scoreboard slot keyed by the cycle a response is due (modulo 16).
    typedef struct {
        bit          v;
        int          due;
        logic [15:0] data;
        logic [15:0] addr;
    } slot_t;

    logic [15:0] mm   [3][32768];
    slot_t       sb   [3][16];
    logic [15:0] last [3];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            last[d] = 16'h0000;
            for (int j = 0; j < 16; j++) sb[d][j].v = 1'b0;
        end
    end

    // Model: accept requests at each rising edge.
    always @(posedge clk) begin
        cyc++;
        if (rst && enable) begin
            for (int d = 0; d < 3; d++) begin
                int idx;
                int due;
                idx = (int'(addr) >> 1) & ((1 << aw_of(d)) - 1);
                if (wr) begin
                    mm[d][idx] = data_in;
                end else begin
                    due = cyc + lat_of(d) - 1;
                    sb[d][due % 16] = '{1'b1, due, mm[d][idx], {addr[15:1], 1'b0}};
                end
            end
        end
    end

    // Model: asynchronous reset drops every in-flight load and zeroes the outputs.
    always @(negedge rst) begin
        for (int d = 0; d < 3; d++) begin
            last[d] = 16'h0000;
            for (int j = 0; j < 16; j++) sb[d][j].v = 1'b0;
        end
    end

    // Compare on every falling edge.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            bit          exp_v;
            bit          exp_b;
            logic [15:0] exp_a;
            int          s;
            s     = cyc % 16;
            exp_v = sb[d][s].v && (sb[d][s].due == cyc);
            exp_a = 16'h0000;
            if (exp_v) begin
                last[d]    = sb[d][s].data;
                exp_a      = sb[d][s].addr;
                sb[d][s].v = 1'b0;
            end
            exp_b = rst && enable && !wr;
            for (int j = 0; j < 16; j++) begin
                if (sb[d][j].v && sb[d][j].due > cyc) exp_b = 1'b1;
            end
            chk($sformatf("data_valid[%0d]@%0d", d, cyc), {15'b0, dv[d]}, {15'b0, exp_v});
            chk($sformatf("data_out[%0d]@%0d", d, cyc), dout[d], last[d]);
            chk($sformatf("busy[%0d]@%0d", d, cyc), {15'b0, bsy[d]}, {15'b0, exp_b});
            if (exp_v) chk($sformatf("resp_addr[%0d]@%0d", d, cyc), raddr[d], exp_a);
        end
    end

    // Present a request for the next edge, then return just after that edge.
    task automatic req(input bit w, input logic [15:0] a, input logic [15:0] dt);
        enable  = 1'b1;
        wr      = w;
        addr    = a;
        data_in = dt;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        enable = 1'b0;
        wr     = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst     = 1'b1;
        enable  = 1'b0;
        wr      = 1'b0;
        addr    = 16'h0000;
        data_in = 16'h0000;
        #2 rst = 1'b0;
        #1;
        chk("reset data_valid", {15'b0, dv[0]}, 16'h0000);
        chk("reset busy", {15'b0, bsy[0]}, 16'h0000);
        chk("reset data_out", dout[0], 16'h0000);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // First load after release: valid exactly at edge N+3.
        req(1'b1, 16'h0010, 16'hBEEF);
        req(1'b0, 16'h0010, 16'h0000);
        idle(2);
        chk("beef early", {15'b0, dv[0]}, 16'h0000);
        idle(1);
        chk("beef valid", {15'b0, dv[0]}, 16'h0001);
        chk("beef data", dout[0], 16'hBEEF);
        chk("beef addr", raddr[0], 16'h0010);
        idle(3);

        // Read-after-write on consecutive cycles.
        req(1'b1, 16'h0020, 16'h1234);
        req(1'b0, 16'h0020, 16'h0000);
        idle(5);

        // Four back-to-back loads.
        for (int i = 0; i < 4; i++) req(1'b1, 16'(2 * i), 16'(i + 1));
        for (int i = 0; i < 4; i++) req(1'b0, 16'(2 * i), 16'h0000);
        idle(6);

        // Odd address reads the even word, echoed address has bit 0 cleared.
        req(1'b0, 16'h0021, 16'h0000);
        idle(3);
        chk("odd data", dout[0], 16'h1234);
        chk("odd addr", raddr[0], 16'h0020);
        idle(3);

        // Aliasing in the 4-bit instance: 0x22 and 0x42 share word 1.
        req(1'b1, 16'h0042, 16'h7777);
        req(1'b1, 16'h0022, 16'h5A5A);
        req(1'b0, 16'h0042, 16'h0000);
        idle(3);
        chk("alias narrow", dout[1], 16'h5A5A);
        chk("alias wide", dout[0], 16'h7777);
        idle(3);

        // Reset with two loads in flight.
        req(1'b0, 16'h0010, 16'h0000);
        req(1'b0, 16'h0020, 16'h0000);
        enable = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("midreset data_valid", {15'b0, dv[0]}, 16'h0000);
        chk("midreset busy", {15'b0, bsy[0]}, 16'h0000);
        chk("midreset data_out", dout[0], 16'h0000);
        @(posedge clk);
        #1 rst = 1'b1;
        idle(6);
        req(1'b0, 16'h0010, 16'h0000);
        idle(6);

        // LATENCY=1: store gives no response, next-cycle load returns immediately.
        req(1'b1, 16'h0030, 16'hCAFE);
        chk("lat1 store no valid", {15'b0, dv[2]}, 16'h0000);
        req(1'b0, 16'h0010, 16'h0000);
        chk("lat1 valid", {15'b0, dv[2]}, 16'h0001);
        chk("lat1 data", dout[2], 16'hBEEF);
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
